// File: rtl/sram_read_distributor_if.sv
// Bus bundle for sram_read_distributor: allocation, scatter commands, SRAM read port, DRAM write line.
// master = surrounding DMA pipeline, slave = the distributor.
interface sram_read_distributor_if #(
    parameter int DBW     = 16,
    parameter int VSIZE   = 32,
    parameter int CSIZE   = 32,
    parameter int LBW0    = 10,
    parameter int LBW1    = 10,
    parameter int LBW     = 10,
    parameter int ICFG_BW = 2
);
    localparam int CV_BW  = $clog2(VSIZE);
    localparam int CV_BW1 = $clog2(VSIZE + 1);
    localparam int CC_BW  = $clog2(CSIZE);

    logic                    alloc_rdy;
    logic                    alloc_ack;
    logic [ICFG_BW-1:0]      i_id;
    logic [LBW:0]            i_size;
    logic                    i_which;
    logic                    cmd_rdy;
    logic                    cmd_ack;
    logic [CC_BW-1:0]        i_cmd_addrofs;
    logic [CV_BW1-1:0]       i_cmd_len;
    logic                    i_cmd_islast;
    logic                    r0_dval;
    logic                    r1_dval;
    logic [LBW0-CV_BW-1:0]   o_rhiaddr0;
    logic [LBW1-CV_BW-1:0]   o_rhiaddr1;
    logic [DBW*VSIZE-1:0]    i_rdata;
    logic                    dramwr_rdy;
    logic                    dramwr_ack;
    logic [ICFG_BW-1:0]      o_id;
    logic [DBW*CSIZE-1:0]    o_dramwr;
    logic [CSIZE-1:0]        o_dramwr_mask;

    modport master (
        output alloc_rdy, i_id, i_size, i_which,
        output cmd_rdy, i_cmd_addrofs, i_cmd_len, i_cmd_islast,
        output i_rdata, dramwr_ack,
        input  alloc_ack, cmd_ack, r0_dval, r1_dval, o_rhiaddr0, o_rhiaddr1,
        input  dramwr_rdy, o_id, o_dramwr, o_dramwr_mask
    );

    modport slave (
        input  alloc_rdy, i_id, i_size, i_which,
        input  cmd_rdy, i_cmd_addrofs, i_cmd_len, i_cmd_islast,
        input  i_rdata, dramwr_ack,
        output alloc_ack, cmd_ack, r0_dval, r1_dval, o_rhiaddr0, o_rhiaddr1,
        output dramwr_rdy, o_id, o_dramwr, o_dramwr_mask
    );
endinterface

// File: rtl/sram_read_distributor.sv
// Reads SRAM vectors from bank 0/1 and scatters their elements into byte-lane-masked DRAM lines.
// Optional macro SRD_ZERO_MASKED_EN: lanes with mask=0 drive 0 on o_dramwr.
module sram_read_distributor #(
    parameter int DBW     = 16,
    parameter int VSIZE   = 32,
    parameter int CSIZE   = 32,
    parameter int LBW0    = 10,
    parameter int LBW1    = 10,
    parameter int LBW     = 10,
    parameter int ICFG_BW = 2
) (
    input logic                     i_clk,
    input logic                     i_rst,
    sram_read_distributor_if.slave  bus
);
    localparam int CV_BW  = $clog2(VSIZE);
    localparam int CV_BW1 = $clog2(VSIZE + 1);
    localparam int CC_BW  = $clog2(CSIZE);
    localparam int LW     = CC_BW + 1;
    localparam int HA0    = LBW0 - CV_BW;
    localparam int HA1    = LBW1 - CV_BW;

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_FETCH = 5'b00010;
    localparam logic [4:0] S_WAIT  = 5'b00100;
    localparam logic [4:0] S_RUN   = 5'b01000;
    localparam logic [4:0] S_FLUSH = 5'b10000;

    logic [4:0]          state;
    logic [ICFG_BW-1:0]  id_q;
    logic [LBW:0]        size_q;
    logic [LBW:0]        consumed;
    logic                which_q;
    logic [CV_BW1-1:0]   vec_ptr;
    logic [CV_BW1-1:0]   cmd_handled;
    logic [HA0-1:0]      hiaddr0;
    logic [HA1-1:0]      hiaddr1;
    logic [DBW-1:0]      vbuf [VSIZE];
    logic [DBW-1:0]      lbuf [CSIZE];
    logic [CSIZE-1:0]    mask;

    function automatic logic [CV_BW1-1:0] min_len(input logic [CV_BW1-1:0] a,
                                                  input logic [CV_BW1-1:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [CV_BW1-1:0] cmd_left, vec_left, n_take, vec_ptr_nx;
    logic [LBW:0]      consumed_nx;
    logic              cmd_done, need_fetch_nx;
    logic [LW-1:0]     lane_base;
    logic              lane_hit [CSIZE];
    logic [CV_BW-1:0]  lane_src [CSIZE];

    assign cmd_left      = bus.i_cmd_len - cmd_handled;
    assign vec_left      = CV_BW1'(VSIZE) - vec_ptr;
    assign n_take        = min_len(cmd_left, vec_left);
    assign cmd_done      = (cmd_left <= vec_left);
    assign vec_ptr_nx    = vec_ptr + n_take;
    assign consumed_nx   = consumed + (LBW+1)'(n_take);
    assign need_fetch_nx = (vec_ptr_nx == CV_BW1'(VSIZE)) && (consumed_nx < size_q);
    assign lane_base     = LW'(bus.i_cmd_addrofs) + LW'(cmd_handled);

    // Each DRAM lane works out which vector element (if any) lands on it; lanes past CSIZE never match.
    always_comb begin
        logic [LW-1:0] d;
        int            s;
        d = '0;
        s = 0;
        for (int j = 0; j < CSIZE; j++) begin
            d           = LW'(j) - lane_base;
            s           = int'(vec_ptr) + int'(d);
            lane_hit[j] = int'(d) < int'(n_take);
            lane_src[j] = CV_BW'(s);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= S_IDLE;
            id_q        <= '0;
            size_q      <= '0;
            consumed    <= '0;
            which_q     <= 1'b0;
            vec_ptr     <= '0;
            cmd_handled <= '0;
            hiaddr0     <= '0;
            hiaddr1     <= '0;
            mask        <= '0;
            for (int i = 0; i < VSIZE; i++) vbuf[i] <= '0;
            for (int j = 0; j < CSIZE; j++) lbuf[j] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.alloc_rdy) begin
                        id_q     <= bus.i_id;
                        size_q   <= bus.i_size;
                        which_q  <= bus.i_which;
                        consumed <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (which_q) hiaddr1 <= hiaddr1 + 1'b1;
                    else         hiaddr0 <= hiaddr0 + 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    for (int i = 0; i < VSIZE; i++) vbuf[i] <= bus.i_rdata[i*DBW +: DBW];
                    vec_ptr <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (bus.cmd_rdy) begin
                        for (int j = 0; j < CSIZE; j++) begin
                            if (lane_hit[j]) begin
                                lbuf[j] <= vbuf[lane_src[j]];
                                mask[j] <= 1'b1;
                            end
                        end
                        vec_ptr  <= vec_ptr_nx;
                        consumed <= consumed_nx;
                        if (cmd_done) begin
                            cmd_handled <= '0;
                            if (bus.i_cmd_islast) state <= S_FLUSH;
                            else if (need_fetch_nx) state <= S_FETCH;
                        end else begin
                            // Command straddles vectors: stays pending across the refetch.
                            cmd_handled <= cmd_handled + n_take;
                            if (need_fetch_nx) state <= S_FETCH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (bus.dramwr_ack) begin
                        mask <= '0;
                        if (consumed == size_q)                 state <= S_IDLE;
                        else if (vec_ptr == CV_BW1'(VSIZE))     state <= S_FETCH;
                        else                                    state <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.alloc_ack     = (state == S_IDLE) && bus.alloc_rdy;
    assign bus.cmd_ack       = (state == S_RUN) && bus.cmd_rdy && cmd_done;
    assign bus.r0_dval       = (state == S_FETCH) && !which_q;
    assign bus.r1_dval       = (state == S_FETCH) && which_q;
    assign bus.o_rhiaddr0    = hiaddr0;
    assign bus.o_rhiaddr1    = hiaddr1;
    assign bus.dramwr_rdy    = (state == S_FLUSH);
    assign bus.o_id          = id_q;
    assign bus.o_dramwr_mask = mask;

    always_comb begin
        bus.o_dramwr = '0;
        for (int j = 0; j < CSIZE; j++) begin
`ifdef SRD_ZERO_MASKED_EN
            bus.o_dramwr[j*DBW +: DBW] = mask[j] ? lbuf[j] : '0;
`else
            bus.o_dramwr[j*DBW +: DBW] = lbuf[j];
`endif
        end
    end
endmodule
